debounce_filter: RTL and testbench
==================================

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on din; legal range is 2 or more.
REQ-002 Parameter STABLE_CYCLES, default 4, extra consecutive agreeing samples required before a level is accepted; legal range is 1 or more.
REQ-003 Parameter CNT_W, default 8, width of the rise-event counter.
REQ-004 clk  input  1  single clock; every register updates on the posedge.
REQ-005 sync_reset  input  1  reset, synchronous and active-high.
REQ-006 din  input  1  raw asynchronous, bouncy level, such as a switch.
REQ-007 q  output  1  debounced registered level; intended as the D input of the downstream flop stage.
REQ-008 rise  output  1  single-cycle pulse when q goes 0->1.
REQ-009 fall  output  1  single-cycle pulse when q goes 1->0.
REQ-010 busy  output  1  high while a candidate level change is being qualified.
REQ-011 rise_cnt  output  CNT_W  count of accepted rising edges.

Function
REQ-012 din SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is s, and no other logic SHALL read din.
REQ-013 FSM states SHALL be LOW, CHK_HIGH, HIGH and CHK_LOW, with stable counter cnt.
REQ-014 LOW: s=1 -> CHK_HIGH with cnt=0; otherwise stay in LOW.
REQ-015 CHK_HIGH: s=0 -> LOW with cnt=0; s=1 and cnt=STABLE_CYCLES-1 -> HIGH; otherwise s=1 -> cnt+1.
REQ-016 HIGH and CHK_LOW SHALL mirror LOW and CHK_HIGH with the polarity of s inverted.
REQ-017 q SHALL be 1 in HIGH and CHK_LOW and 0 in LOW and CHK_HIGH; q is registered.
REQ-018 A change of q SHALL require STABLE_CYCLES+1 consecutive equal samples of s.
REQ-019 Any shorter excursion of s SHALL leave q, rise and fall unchanged.
REQ-020 rise SHALL be asserted on the same edge q goes 0->1, for exactly one cycle; fall likewise for 1->0.
REQ-021 rise and fall SHALL never be high together.
REQ-022 busy SHALL be 1 exactly when the state is CHK_HIGH or CHK_LOW.
REQ-023 Latency: a clean din step before edge 1 SHALL change q at edge SYNC_STAGES+STABLE_CYCLES+1, which is edge 7 with defaults.
REQ-024 rise_cnt SHALL increment by 1 on each rise pulse and wrap from 2^CNT_W-1 to 0 with no flag.
REQ-025 cnt SHALL be wide enough for STABLE_CYCLES-1 and SHALL never exceed it.

Reset
REQ-026 While sync_reset=1 at a posedge, the following SHALL all become 0: sync chain, state=LOW, cnt, q, rise, fall, busy and rise_cnt.
REQ-027 Reset SHALL win over all other activity, including a qualification in progress, and SHALL abort it without a pulse.
REQ-028 If din is held at 1 through reset, q SHALL rise with a rise pulse at the REQ-023 latency, counted from the first non-reset edge.

Structure
REQ-029 Package debounce_pkg SHALL hold the FSM state enum and the default constants: SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=8.
REQ-030 Sub-module sync_chain, parameterised by depth with ports clk, sync_reset, d and q, SHALL implement REQ-012; everything else is flat.

Verification
REQ-031 Bench SHALL cover the following scenario: reset for 5 cycles, then din 0->1 stable -> q=1 and rise=1 at the 7th edge after the change, rise low on the next cycle, rise_cnt=1.
REQ-032 Bench SHALL cover the following scenario: din high for 3 cycles, then low -> q stays 0, no rise, busy pulses, rise_cnt unchanged.
REQ-033 Bench SHALL cover the following scenario: from HIGH, din bounces 1,0,1,0,0... then stays 0 -> exactly one fall pulse, 5 edges after the final stable sample of s.
REQ-034 Bench SHALL cover the following scenario: sync_reset asserted during CHK_HIGH with cnt=2 -> next cycle state LOW and all outputs 0, no rise.
REQ-035 Bench SHALL cover the following scenario: CNT_W=2 with 5 accepted rising edges -> rise_cnt sequence 1,2,3,0,1.
REQ-036 Bench SHALL cover the following scenario: STABLE_CYCLES=1 with din stable -> q changes at edge 4; a 1-cycle glitch on s is rejected.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: state encoding and default sizing shared by the debounce filter.
package debounce_pkg;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_t;
endpackage

// File: rtl/debounce_filter_sync_chain.sv
// sync_chain: multi-flop synchronizer for an asynchronous single-bit input.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] r_ff;
  always_ff @(posedge clk)
    r_ff <= sync_reset ? '0 : {r_ff[DEPTH-2:0], d};
  assign q = r_ff[DEPTH-1];
endmodule

// File: rtl/debounce_filter.sv
// debounce_filter: synchronizes a bouncy level and accepts it only after it holds steady.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             din,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] rise_cnt
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_rise_cnt;
  logic r_q, r_rise, r_fall, r_busy;
  logic w_s, w_done, w_q_next, w_rise, w_fall;
  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk(clk),
    .sync_reset(sync_reset),
    .d(din),
    .q(w_s)
  );
  always_comb begin
    w_next = r_state;
    w_cnt_next = '0;
    w_done = r_cnt == CMAX;
    case (r_state)
      LOW: w_next = w_s ? CHK_HIGH : LOW;
      CHK_HIGH: begin
        w_next = !w_s ? LOW : w_done ? HIGH : CHK_HIGH;
        w_cnt_next = (w_s && !w_done) ? r_cnt + 1'b1 : '0;
      end
      HIGH: w_next = w_s ? HIGH : CHK_LOW;
      CHK_LOW: begin
        w_next = w_s ? HIGH : w_done ? LOW : CHK_LOW;
        w_cnt_next = (!w_s && !w_done) ? r_cnt + 1'b1 : '0;
      end
    endcase
    w_q_next = w_next == HIGH || w_next == CHK_LOW;
    w_rise = w_q_next && !r_q;
    w_fall = !w_q_next && r_q;
  end
  // Outputs are registered from the next state so q/rise/fall/busy flip on the same edge.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state <= LOW;
      r_cnt <= '0;
      r_q <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_busy <= 1'b0;
      r_rise_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_next;
      r_q <= w_q_next;
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_busy <= w_next == CHK_HIGH || w_next == CHK_LOW;
      r_rise_cnt <= r_rise_cnt + CNT_W'(w_rise);
    end
  end
  assign q = r_q;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;
  assign rise_cnt = r_rise_cnt;
endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: three parameterisations checked every cycle against a sample-history model.
module tb_debounce_filter;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0;
  logic q0, r0, f0, b0, q1, r1, f1, b1, q2, r2, f2, b2;
  logic [7:0] c0, c2;
  logic [1:0] c1;
  int nvec = 0, nfail = 0;
  int ss[3] = '{2, 2, 2};
  int sc[3] = '{4, 4, 1};
  int cw[3] = '{8, 2, 8};
  bit pipe[3][8];
  bit hist[3][8];
  int hn[3];
  bit mq[3], mr[3], mf[3], mb[3];
  int mc[3];
  always #5 clk = ~clk;
  debounce_filter u0 (.clk(clk), .sync_reset(rst), .din(din), .q(q0), .rise(r0), .fall(f0), .busy(b0), .rise_cnt(c0));
  debounce_filter #(.CNT_W(2)) u1 (.clk(clk), .sync_reset(rst), .din(din), .q(q1), .rise(r1), .fall(f1), .busy(b1), .rise_cnt(c1));
  debounce_filter #(.STABLE_CYCLES(1)) u2 (.clk(clk), .sync_reset(rst), .din(din), .q(q2), .rise(r2), .fall(f2), .busy(b2), .rise_cnt(c2));
  task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  // Model: q flips once the last STABLE_CYCLES+1 samples of s all disagree with it.
  always @(posedge clk) begin
    bit s, flip;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) pipe[i][k] = 0;
        hn[i] = 0; mq[i] = 0; mr[i] = 0; mf[i] = 0; mb[i] = 0; mc[i] = 0;
      end else begin
        s = pipe[i][ss[i]-1];
        for (int k = 7; k > 0; k--) pipe[i][k] = pipe[i][k-1];
        pipe[i][0] = din;
        for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = s;
        if (hn[i] < 8) hn[i]++;
        flip = hn[i] >= sc[i] + 1;
        for (int k = 0; k <= sc[i]; k++) if (hist[i][k] == mq[i]) flip = 0;
        mr[i] = 0; mf[i] = 0;
        if (flip) begin
          mq[i] = ~mq[i];
          mr[i] = mq[i];
          mf[i] = ~mq[i];
          if (mr[i]) mc[i] = (mc[i] + 1) % (1 << cw[i]);
        end
        mb[i] = s != mq[i];
      end
    end
  end
  always @(negedge clk) begin
    chk("u0", {q0, r0, f0, b0, c0}, {mq[0], mr[0], mf[0], mb[0], 8'(mc[0])});
    chk("u1", {q1, r1, f1, b1, 6'd0, c1}, {mq[1], mr[1], mf[1], mb[1], 8'(mc[1])});
    chk("u2", {q2, r2, f2, b2, c2}, {mq[2], mr[2], mf[2], mb[2], 8'(mc[2])});
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int falls, rises, busy_seen, got;
    int e[5] = '{1, 2, 3, 0, 1};
    bit seq[5] = '{0, 1, 0, 1, 0};
    step(5);
    chk("reset_state", {q0, r0, f0, b0, c0}, 12'h000);
    rst = 0; din = 1;
    step(3);
    chk("sc1_q_edge3", q2, 0);
    step(1);
    chk("sc1_q_edge4", q2, 1);
    step(2);
    chk("q_edge6", {q0, r0}, 2'b00);
    step(1);
    chk("q_rise_edge7", {q0, r0}, 2'b11);
    chk("model_q_edge7", mq[0], 1);
    step(1);
    chk("rise_low_cnt1", {r0, c0}, {1'b0, 8'd1});
    din = 0;
    step(12);
    din = 1;
    step(3);
    din = 0;
    falls = 0; rises = 0; busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      rises += r0;
      busy_seen |= b0;
    end
    chk("short_pulse_q_cnt", {q0, c0}, {1'b0, 8'd1});
    chk("short_pulse_no_rise", rises, 0);
    chk("short_pulse_busy", busy_seen, 1);
    din = 1;
    step(5);
    chk("chk_high_busy", b0, 1);
    rst = 1;
    step(1);
    chk("reset_abort", {q0, r0, f0, b0, c0}, 12'h000);
    rst = 0;
    step(6);
    chk("post_reset_q6", q0, 0);
    step(1);
    chk("post_reset_rise7", {q0, r0, c0}, {2'b11, 8'd1});
    step(2);
    for (int k = 0; k < 20; k++) begin
      din = k < 5 ? seq[k] : 1'b0;
      step(1);
      falls += f0;
    end
    chk("bounce_one_fall", falls, 1);
    chk("bounce_q_low", q0, 0);
    rst = 1;
    step(2);
    rst = 0;
    for (int p = 0; p < 5; p++) begin
      din = 1; got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
        step(1);
        if (r1) begin
          got = 1;
          chk("wrap_cnt", 12'(c1), 12'(e[p]));
        end
      end
      if (got == 0) begin
        nvec++; nfail++;
        $display("FAIL wrap_rise_timeout: got no rise expected rise %0d", p);
      end
      din = 0;
      step(12);
    end
    din = 1;
    step(1);
    din = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("sc1_glitch", {q2, r2}, 2'b00);
    end
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 30) == 0) begin
        rst = 1;
        step($urandom_range(1, 3));
        rst = 0;
      end
      din = 1'($urandom_range(0, 1));
      step($urandom_range(1, 9));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
